// File: rtl/pwm_led_driver.sv
// pwm_led_driver
//   Turns a BITS-wide brightness level into a PWM waveform on one LED pin and
//   emits a one-cycle strobe at every PWM period boundary. The level is
//   double-buffered into a shadow duty register that only reloads at period
//   boundaries (or continuously while idle). This keeps a changing level from
//   ever producing a truncated pulse.
//
// Parameters
//   BITS        width of level/duty; a PWM period is 2^BITS-1 steps
//   PRESCALE    clk cycles per PWM step (>= 1)
//   ACTIVE_HIGH 1: led high when lit; 0: inverted pin
//
// Ports
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   level      in   requested brightness (0 = off, 2^BITS-1 = fully on)
//   enable     in   1 = run PWM, 0 = idle with LED dark
//   led        out  registered PWM pin
//   periodEnd  out  registered one-cycle strobe marking the start of a period
//   dutyActive out  duty currently being applied (shadow register)

module pwm_led_driver #(
  parameter int BITS        = 4,
  parameter int PRESCALE    = 1,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [BITS-1:0] level,
  input  logic            enable,
  output logic            led,
  output logic            periodEnd,
  output logic [BITS-1:0] dutyActive
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  // cnt runs 0..MAX-1 with MAX = 2^BITS-1, so its last value is 2^BITS-2.
  localparam logic [BITS-1:0] CNT_LAST = BITS'((2 ** BITS) - 2);
  localparam logic            LED_ON   = (ACTIVE_HIGH != 0);
  localparam logic            LED_OFF  = !LED_ON;

  logic [PW-1:0]   pre;
  logic [BITS-1:0] cnt;
  logic [BITS-1:0] duty;
  logic            tick;
  logic            wrap;
  logic            lit;

  // Lit while the step counter is below the duty. Because cnt never reaches
  // MAX, duty = MAX keeps the LED on for the whole period.
  function automatic logic duty_lit(input logic [BITS-1:0] c,
                                    input logic [BITS-1:0] d);
    return (c < d);
  endfunction

  assign tick = enable && (pre == PRE_LAST);
  assign wrap = tick && (cnt == CNT_LAST);
  assign lit  = duty_lit(cnt, duty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      cnt       <= '0;
      duty      <= '0;
      periodEnd <= 1'b0;
      led       <= LED_OFF;
    end else if (!enable) begin
      // Idle: abort any period without a strobe and keep the shadow duty
      // tracking level, so the first period after enable uses the last level.
      pre       <= '0;
      cnt       <= '0;
      duty      <= level;
      periodEnd <= 1'b0;
      led       <= LED_OFF;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      if (wrap) begin
        duty <= level;
      end
      // The extra term only matters for a degenerate one-step period; it
      // guarantees the strobe is never high on two consecutive cycles.
      periodEnd <= wrap && !periodEnd;
      // Output stage: led reflects the cnt/duty state one clk later.
      led       <= lit ? LED_ON : LED_OFF;
    end
  end

  assign dutyActive = duty;

endmodule

// File: tb/tb_pwm_led_driver.sv
module tb_pwm_led_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] level;
  logic       enable;

  logic       led1, pe1, led3, pe3, ledn, pen;
  logic [3:0] da1, da3, dan;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Three configurations share one stimulus stream.
  pwm_led_driver #(.BITS(4), .PRESCALE(1), .ACTIVE_HIGH(1)) u_p1 (
    .clk(clk), .reset_n(reset_n), .level(level), .enable(enable),
    .led(led1), .periodEnd(pe1), .dutyActive(da1));

  pwm_led_driver #(.BITS(4), .PRESCALE(3), .ACTIVE_HIGH(1)) u_p3 (
    .clk(clk), .reset_n(reset_n), .level(level), .enable(enable),
    .led(led3), .periodEnd(pe3), .dutyActive(da3));

  pwm_led_driver #(.BITS(4), .PRESCALE(1), .ACTIVE_HIGH(0)) u_inv (
    .clk(clk), .reset_n(reset_n), .level(level), .enable(enable),
    .led(ledn), .periodEnd(pen), .dutyActive(dan));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance is tracked as a single position within the period
  // (0 .. PRESCALE*15-1); the step index is position / PRESCALE.
  function automatic int ps(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic logic ah(input int i);
    return (i != 2);
  endfunction

  int         pos   [3] = '{0, 0, 0};
  logic [3:0] mduty [3] = '{4'd0, 4'd0, 4'd0};
  logic       mled  [3] = '{1'b0, 1'b0, 1'b1};
  logic       mpe   [3] = '{1'b0, 1'b0, 1'b0};

  always begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        pos[i] = 0; mduty[i] = 4'd0; mpe[i] = 1'b0; mled[i] = !ah(i);
      end else if (!enable) begin
        pos[i] = 0; mduty[i] = level; mpe[i] = 1'b0; mled[i] = !ah(i);
      end else begin
        mled[i] = ((pos[i] / ps(i)) < int'(mduty[i])) ? ah(i) : !ah(i);
        if (pos[i] == ps(i) * 15 - 1) begin
          pos[i] = 0; mduty[i] = level; mpe[i] = 1'b1;
        end else begin
          pos[i] = pos[i] + 1; mpe[i] = 1'b0;
        end
      end
    end
    #1;
    chk("model_led_p1",  32'(led1), 32'(mled[0]));
    chk("model_pe_p1",   32'(pe1),  32'(mpe[0]));
    chk("model_duty_p1", 32'(da1),  32'(mduty[0]));
    chk("model_led_p3",  32'(led3), 32'(mled[1]));
    chk("model_pe_p3",   32'(pe3),  32'(mpe[1]));
    chk("model_duty_p3", 32'(da3),  32'(mduty[1]));
    chk("model_led_inv", 32'(ledn), 32'(mled[2]));
    chk("model_pe_inv",  32'(pen),  32'(mpe[2]));
    chk("model_duty_inv",32'(dan),  32'(mduty[2]));
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pesel(input int which);
    return (which == 0) ? pe1 : (which == 1) ? pe3 : pen;
  endfunction

  task automatic wait_pe(input int which, input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pesel(which) && n < maxc);
    if (!pesel(which)) begin
      nvec++;
      nerr++;
      $display("FAIL wait_pe%0d: no periodEnd within %0d cycles", which, maxc);
    end
  endtask

  typedef struct {
    logic [3:0]  lvl;
    int          periods;
    logic [14:0] pat;   // bit j = led in cycle j after the periodEnd cycle
    int          pe;    // strobes seen in those 15 cycles
  } vec_t;

  vec_t tbl [6];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, lit, dark, hi, pc, dbl;
    logic [14:0] pat, patn;
    logic prev;

    tbl[0] = '{4'd5,  1, 15'h001F, 1};
    tbl[1] = '{4'd0,  3, 15'h0000, 1};
    tbl[2] = '{4'd15, 3, 15'h7FFF, 1};
    tbl[3] = '{4'd10, 1, 15'h03FF, 1};
    tbl[4] = '{4'd1,  1, 15'h0001, 1};
    tbl[5] = '{4'd14, 1, 15'h3FFF, 1};

    // reset state, asserted asynchronously before any clock edge
    reset_n = 1'b1; enable = 1'b0; level = 4'd9;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_led_p1",  32'(led1), 0);
    chk("rst_pe_p1",   32'(pe1),  0);
    chk("rst_duty_p1", 32'(da1),  0);
    chk("rst_led_inv", 32'(ledn), 1);
    chk("rst_duty_p3", 32'(da3),  0);

    repeat (3) step();
    reset_n = 1'b1;
    level = 4'd5;
    step(); step();
    chk("idle_duty_load", 32'(da1), 5);
    chk("idle_led_p1", 32'(led1), 0);

    enable = 1'b1;
    wait_pe(0, 40, n);
    chk("first_period_len", 32'(n), 15);

    // table-driven period shapes
    foreach (tbl[k]) begin
      level = tbl[k].lvl;
      wait_pe(0, 40, n);
      for (int p = 0; p < tbl[k].periods; p++) begin
        chk("tbl_duty", 32'(da1), 32'(tbl[k].lvl));
        pat = '0; patn = '0; pc = 0;
        for (int j = 0; j < 15; j++) begin
          step();
          pat[j]  = led1;
          patn[j] = ~ledn;
          pc += pe1 ? 1 : 0;
        end
        chk("tbl_pattern", 32'(pat), 32'(tbl[k].pat));
        chk("tbl_pattern_inv", 32'(patn), 32'(tbl[k].pat));
        chk("tbl_pe_count", 32'(pc), 32'(tbl[k].pe));
      end
    end

    // level change mid-period only takes effect at the next boundary
    level = 4'd5;
    wait_pe(0, 40, n);
    lit = 0;
    for (int j = 0; j < 14; j++) begin
      step();
      lit += led1 ? 1 : 0;
      if (j == 6) level = 4'd10;
    end
    chk("mid_duty_hold", 32'(da1), 5);
    step();
    lit += led1 ? 1 : 0;
    chk("mid_pe", 32'(pe1), 1);
    chk("mid_duty_new", 32'(da1), 10);
    chk("mid_lit_old", 32'(lit), 5);
    lit = 0;
    repeat (15) begin
      step();
      lit += led1 ? 1 : 0;
    end
    chk("mid_lit_new", 32'(lit), 10);

    // PRESCALE = 3
    level = 4'd4;
    wait_pe(1, 100, n);
    wait_pe(1, 100, n);
    chk("p3_period_len", 32'(n), 45);
    lit = 0; pc = 0; dbl = 0; prev = pe3;
    repeat (45) begin
      step();
      lit += led3 ? 1 : 0;
      pc  += pe3 ? 1 : 0;
      if (pe3 && prev) dbl++;
      prev = pe3;
    end
    chk("p3_lit", 32'(lit), 12);
    chk("p3_pe_count", 32'(pc), 1);
    chk("p3_pe_width", 32'(dbl), 0);
    chk("p3_pe_at_end", 32'(pe3), 1);

    // inverted pin and idle behaviour
    level = 4'd3;
    wait_pe(2, 40, n);
    wait_pe(2, 40, n);
    lit = 0;
    repeat (15) begin
      step();
      lit += ledn ? 0 : 1;
    end
    chk("inv_low_cycles", 32'(lit), 3);
    enable = 1'b0;
    step();
    hi = 0; pc = 0;
    repeat (20) begin
      step();
      hi += ledn ? 1 : 0;
      pc += (pe1 ? 1 : 0) + (pe3 ? 1 : 0) + (pen ? 1 : 0);
    end
    chk("idle_inv_high", 32'(hi), 20);
    chk("idle_no_pe", 32'(pc), 0);

    // asynchronous reset in the middle of a lit pulse
    enable = 1'b1;
    level  = 4'd10;
    wait_pe(0, 40, n);
    wait_pe(0, 40, n);
    step(); step(); step();
    chk("pre_rst_led", 32'(led1), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_led_p1",  32'(led1), 0);
    chk("async_rst_pe_p1",   32'(pe1),  0);
    chk("async_rst_duty_p1", 32'(da1),  0);
    chk("async_rst_led_inv", 32'(ledn), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0; dark = 0;
    do begin
      step();
      n++;
      dark += led1 ? 1 : 0;
    end while (!pe1 && n < 40);
    chk("post_rst_pe_delay", 32'(n), 15);
    chk("post_rst_dark", 32'(dark), 0);

    // randomized level / enable traffic checked by the model
    repeat (900) begin
      step();
      if ($urandom_range(7) == 0)  level  = 4'($urandom_range(15));
      if ($urandom_range(39) == 0) enable = ~enable;
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pwm_led_driver.md
# pwm_led_driver

Converts a BITS-wide brightness level into a PWM waveform on one LED pin and emits a one-cycle strobe at every PWM period boundary. Sits directly downstream of the breathing-LED triangle counter: it consumes that counter's level output and returns `periodEnd`, the step strobe that paces the counter. The level is double-buffered and applied only at period boundaries, so a changing level never produces a truncated or glitched pulse.

## Interface
- `BITS`, 4: width of level/duty; PWM period is 2^BITS−1 steps.
- `PRESCALE`, 1: clk cycles per PWM step; legal range ≥1.
- `ACTIVE_HIGH`, 1: 1 drives `led` high when lit; 0 inverts the pin.

- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `level`  in  BITS  requested brightness; 0 = off, 2^BITS−1 = fully on.
- `enable`  in  1  1 = run PWM; 0 = hold idle, LED dark.
- `led`  out  1  registered PWM pin, polarity per `ACTIVE_HIGH`.
- `periodEnd`  out  1  registered one-cycle strobe, start of each new period.
- `dutyActive`  out  BITS  duty currently being applied (shadow register).

## Operation
- MAX = 2^BITS−1. Registers: `pre` (0..PRESCALE−1), `cnt` (0..MAX−1), `duty` (BITS), `led`, `periodEnd`.
- Step tick: `tick = enable && pre == PRESCALE−1`. With `enable`, `pre` increments each cycle and wraps to 0 on tick.
- On tick: if `cnt == MAX−1`, then `cnt`←0, `duty`←`level`, `periodEnd`←1. Otherwise `cnt`←`cnt`+1 and `periodEnd`←0.
- All cycles without a wrap: `periodEnd`←0. It is never high two consecutive cycles, including when PRESCALE=1.
- Lit condition: `cnt < duty`, using BITS-wide unsigned compare. duty=0 → never lit. duty=MAX → always lit, since `cnt` never reaches MAX.
- `led` register ← lit XNOR ACTIVE_HIGH when `enable`, else the inactive level. The value is sampled from the current-cycle `cnt`/`duty`.
- `enable`=0: `pre`←0, `cnt`←0, `periodEnd`←0, `duty`←`level` every cycle, `led`←inactive. After `enable` rises, the first period uses the level present in the last disabled cycle.
- `level` changes mid-period are ignored until the next wrap. `dutyActive` = `duty`.
- No states beyond IDLE (`enable`=0) and RUN. Moving RUN→IDLE aborts the period immediately, with no completion strobe.

## Timing
- Reset (async assert, any time): `pre`=0, `cnt`=0, `duty`=0, `dutyActive`=0, `periodEnd`=0, `led`=inactive (0 if ACTIVE_HIGH else 1). Deassertion is used synchronously by the first following edge.
- Period length = PRESCALE·MAX clk cycles. Lit time per period = PRESCALE·duty cycles.
- `led` latency: 1 clk after the `cnt`/`duty` state that produces it.
- `periodEnd` is high in the cycle where `cnt`=0 and the new `duty` are first visible. The first `led` cycle of that period follows one clk later.
- Upstream handshake: the upstream counter updates `level` on `periodEnd`. Any `level` settled before the next wrap tick is captured; there is no back-pressure.
- Reset released with `enable`=1: the first period runs with duty=0 (dark), then loads `level` at the first wrap.

## Test plan
- BITS=4, PRESCALE=1, `enable`=0 then 1, `level`=5 → period 15 clk, `led` high exactly 5 consecutive cycles per period, `periodEnd` every 15 clk, `dutyActive`=5.
- `level`=0 and `level`=15, with `enable` held → `led` constant 0 and constant 1 respectively across ≥3 periods. `periodEnd` keeps pulsing every 15 clk.
- PRESCALE=3, `level`=4 → period 45 clk, `led` high 12 cycles, `periodEnd` width exactly 1 clk.
- Change `level` 5→10 mid-period → current period still 5 lit cycles. Next period 10 lit cycles. `dutyActive` changes in the `periodEnd` cycle.
- Assert `reset_n`=0 mid-lit-pulse → `led`, `periodEnd`, `dutyActive` go to 0 immediately, without waiting for `clk`. After release with `enable`=1, the first period is dark and `periodEnd` comes 15 clk later.
- ACTIVE_HIGH=0, `level`=3 → `led` low 3 cycles per 15. `enable`=0 forces `led`=1 and stops `periodEnd`.
